// File: rtl/ro_scan_pkg.sv
// ro_scan_pkg: shared types and constants for the ring-oscillator scan
// controller.
//   state_t    - controller FSM state encoding
//   SETTLE_MIN - the smallest usable settle length. The synchronizer plus
//                edge detector need three samples of the new RO before the
//                gate opens.
//   cnt_max()  - all-ones value for a counter of a given width
package ro_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int SETTLE_MIN = 3;

    function automatic logic [63:0] cnt_max(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: samples one asynchronous RO output and counts its
// rising edges.
//   clk, rst_n - system clock, async active-low reset
//   clr        - clears the synchronizer, the edge history and the count
//   en         - count detected edges while high
//   async_in   - raw RO output, asynchronous to clk
//   cnt_nxt    - count including this cycle's edge. The controller latches
//                it on the last gate cycle.
// Build option: RO_SCAN_SATURATE_EN makes the count stick at all-ones
// instead of wrapping.
module ro_edge_counter
    import ro_scan_pkg::*;
#(
    parameter int CNT_W = 24
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             async_in,
    output logic [CNT_W-1:0] cnt_nxt
);

    // [0],[1]: two-flop synchronizer; [2]: previous synchronized value
    logic [2:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;

`ifdef RO_SCAN_SATURATE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
`endif

    assign w_edge = r_sync[1] & ~r_sync[2];

    always_comb begin
        cnt_nxt = r_cnt;
        if (en && w_edge) begin
`ifdef RO_SCAN_SATURATE_EN
            if (r_cnt != CNT_MAX) begin
                cnt_nxt = r_cnt + CNT_W'(1);
            end
`else
            cnt_nxt = r_cnt + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
        end else if (clr) begin
            r_sync <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[1:0], async_in};
            r_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ro_scan_ctrl.sv
// ro_scan_ctrl: scans the RO array one oscillator at a time. Each
// oscillator is enabled and allowed to settle. Its rising edges are then
// counted over a gate window, and the count is offered on a valid/ready
// port.
//   clk, rst_n      - system clock, async active-low reset
//   start, abort    - begin a scan (IDLE only) / terminate a running scan
//   gate_cycles     - gate length, latched on start (0 acts as 1)
//   ro_in, ro_en    - raw RO outputs / one-hot-or-zero RO enables
//   res_valid/ready - result handshake; res_idx, res_count are the payload
//   busy, done      - not idle / one-cycle pulse after the last transfer
// Build option: RO_SCAN_SATURATE_EN (count saturates instead of wrapping).
//
// state     | meaning
// ST_IDLE   | waiting for start, all enables off
// ST_SETTLE | RO[idx] enabled, letting it settle and filling the synchronizer
// ST_GATE   | RO[idx] enabled, counting edges
// ST_REPORT | enables off, result held until accepted
module ro_scan_ctrl
    import ro_scan_pkg::*;
#(
    parameter  int NUM_RO = 20,
    parameter  int GATE_W = 16,
    parameter  int CNT_W  = 24,
    parameter  int SETTLE = 4,
    localparam int IDX_W  = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy,
    output logic              done
);

    localparam logic [GATE_W-1:0] SETTLE_LD = GATE_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_RO - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [GATE_W-1:0] r_gate;
    logic [GATE_W-1:0] r_tmr;

    logic              w_ro_sel;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;

    assign w_ro_sel  = ro_in[r_idx];
    // Clearing during REPORT as well as IDLE means every SETTLE starts with
    // an empty synchronizer, so no edge leaks from the previous RO.
    assign w_cnt_clr = (r_state == ST_IDLE) || (r_state == ST_REPORT);
    assign w_cnt_en  = (r_state == ST_GATE);
    assign w_idx_nxt = r_idx + IDX_W'(1);

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_cnt_clr),
        .en       (w_cnt_en),
        .async_in (w_ro_sel),
        .cnt_nxt  (w_cnt_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_gate    <= '0;
            r_tmr     <= '0;
            ro_en     <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((r_state != ST_IDLE) && abort) begin
                r_state   <= ST_IDLE;
                ro_en     <= '0;
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_SETTLE;
                            r_gate  <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
                            r_idx   <= '0;
                            r_tmr   <= SETTLE_LD;
                            ro_en   <= NUM_RO'(1);
                            busy    <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_tmr == '0) begin
                            r_state <= ST_GATE;
                            r_tmr   <= r_gate - GATE_W'(1);
                        end else begin
                            r_tmr <= r_tmr - GATE_W'(1);
                        end
                    end
                    ST_GATE: begin
                        if (r_tmr == '0) begin
                            r_state   <= ST_REPORT;
                            ro_en     <= '0;
                            res_valid <= 1'b1;
                            res_idx   <= r_idx;
                            res_count <= w_cnt_nxt;
                        end else begin
                            r_tmr <= r_tmr - GATE_W'(1);
                        end
                    end
                    ST_REPORT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_state <= ST_SETTLE;
                                r_idx   <= w_idx_nxt;
                                r_tmr   <= SETTLE_LD;
                                ro_en   <= NUM_RO'(1) << w_idx_nxt;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ro_scan_ctrl.sv
module tb_ro_scan_ctrl;

    localparam int N  = 20;
    localparam int GW = 16;
    localparam int CW = 24;
    localparam int S  = 4;

    logic          clk;
    logic          rst_n;
    logic          start, abort, res_ready;
    logic [GW-1:0] gate_cycles;
    logic [N-1:0]  ro_in, ro_en;
    logic          res_valid, busy, done;
    logic [4:0]    res_idx;
    logic [CW-1:0] res_count;

    // second instance: narrow counter to exercise wrap / saturation
    logic          start2, tog;
    logic [1:0]    ro_en2;
    logic          res_valid2, busy2, done2;
    logic [0:0]    res_idx2;
    logic [3:0]    res_count2;
    logic [1:0]    ro_in2;

    assign ro_in2 = {tog, tog};

    ro_scan_ctrl #(.NUM_RO(N), .GATE_W(GW), .CNT_W(CW), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .ro_in(ro_in), .ro_en(ro_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_count(res_count), .busy(busy), .done(done)
    );

    ro_scan_ctrl #(.NUM_RO(2), .GATE_W(16), .CNT_W(4), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .gate_cycles(16'd100), .ro_in(ro_in2), .ro_en(ro_en2),
        .res_valid(res_valid2), .res_ready(1'b1), .res_idx(res_idx2),
        .res_count(res_count2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- input drivers (change 2 time units after posedge)
    int  ro_mode = 0;   // 0: zero, 1: RO3 square wave period 4, 2: random
    bit  rdy_mode = 0;  // 0: rdy_fix, 1: random ready
    bit  rdy_fix = 1;
    int  cyc_i = 0;

    always begin
        @(posedge clk);
        #2;
        cyc_i++;
        case (ro_mode)
            1:       ro_in = ((cyc_i % 4) < 2) ? N'(8) : '0;
            2:       ro_in = N'($urandom);
            default: ro_in = '0;
        endcase
        tog = ~tog;
        res_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end

    // ---------------- behavioural model
    // Per RO: cycles 1..S settle, S+1..S+G gate, then a report until accepted.
    // An edge is counted at the clock edge that ends gate cycle k when the
    // input was sampled high two edges earlier and low three edges earlier.
    logic [N-1:0] h1, h2, h3;
    bit           m_busy, m_rep;
    int           m_idx, m_ph, m_G;
    longint       m_cnt;
    logic [N-1:0] e_ro_en;
    bit           e_valid, e_busy, e_done;
    longint       e_idx, e_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_busy = 0; m_rep = 0; m_idx = 0; m_ph = 0; m_G = 1; m_cnt = 0;
            e_ro_en = '0; e_valid = 0; e_busy = 0; e_done = 0; e_idx = 0; e_cnt = 0;
        end else begin
            e_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_rep = 0; m_idx = 0; m_ph = 1; m_cnt = 0;
                    m_G = (gate_cycles == 0) ? 1 : int'(gate_cycles);
                end
            end else if (abort) begin
                m_busy = 0; m_rep = 0;
            end else if (m_rep) begin
                if (res_ready) begin
                    m_rep = 0;
                    if (m_idx < N - 1) begin
                        m_idx++; m_ph = 1; m_cnt = 0;
                    end else begin
                        m_busy = 0; e_done = 1;
                    end
                end
            end else begin
                if (m_ph > S && h2[m_idx] && !h3[m_idx]) begin
                    m_cnt = m_cnt + 1;
`ifdef RO_SCAN_SATURATE_EN
                    if (m_cnt > (64'd1 << CW) - 1) m_cnt = (64'd1 << CW) - 1;
`else
                    m_cnt = m_cnt % (64'd1 << CW);
`endif
                end
                if (m_ph == S + m_G) begin
                    m_rep = 1; e_idx = m_idx; e_cnt = m_cnt;
                end else begin
                    m_ph++;
                end
            end
            h3 = h2; h2 = h1; h1 = ro_in;
            e_busy  = m_busy;
            e_valid = m_rep;
            e_ro_en = (m_busy && !m_rep) ? (N'(1) << m_idx) : '0;
        end
    end

    // ---------------- compare process and transfer monitors
    int     done_cnt = 0, done2_cnt = 0;
    int     q_idx[$], q_cnt[$];
    int     q2_cnt[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (done2) done2_cnt++;
            if (res_valid && res_ready) begin
                q_idx.push_back(int'(res_idx));
                q_cnt.push_back(int'(res_count));
            end
            if (res_valid2) q2_cnt.push_back(int'(res_count2));
        end
        if (chk_on && rst_n) begin
            chk("ro_en", 64'(ro_en), 64'(e_ro_en));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("res_valid", 64'(res_valid), 64'(e_valid));
            chk("done", 64'(done), 64'(e_done));
            if (e_valid) begin
                chk("res_idx", 64'(res_idx), 64'(e_idx));
                chk("res_count", 64'(res_count), 64'(e_cnt));
            end
            if (busy && !res_valid) chk("ro_en_onehot", 64'($onehot(ro_en)), 64'd1);
        end
    end

    // ---------------- helpers
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int g);
        gate_cycles = GW'(g);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk({nm, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic wait_en(input int bitn, input int budget, input string nm);
        int n = 0;
        while (!ro_en[bitn] && n < budget) begin
            cyc(1);
            n++;
        end
        chk({nm, "_en_seen"}, 64'(ro_en[bitn]), 64'd1);
    endtask

    // ---------------- main sequence
    initial begin
        int d0, n, cap, ok;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        gate_cycles = '0; ro_in = '0; res_ready = 1'b1; tog = 1'b0;
        #23;
        chk("rst_ro_en", 64'(ro_en), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_idx", 64'(res_idx), 64'd0);
        chk("rst_count", 64'(res_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(2);
        chk_on = 1;

        // narrow-counter instance runs alongside scan A
        start2 = 1'b1;
        // scan A: all ROs quiet, gate 100
        ro_mode = 0; rdy_fix = 1; rdy_mode = 0;
        q_idx.delete(); q_cnt.delete();
        d0 = done_cnt;
        do_start(100);
        start2 = 1'b0;
        chk("a_busy_cycle1", 64'(busy), 64'd1);
        chk("a_ro_en_cycle1", 64'(ro_en), 64'd1);
        wait_done(3000, "a");
        cyc(5);
        chk("a_done_once", 64'(done_cnt - d0), 64'd1);
        chk("a_num_results", 64'(q_idx.size()), 64'd20);
        ok = 1;
        foreach (q_idx[i]) if (q_idx[i] != i || q_cnt[i] != 0) ok = 0;
        chk("a_idx_seq_zero_counts", 64'(ok), 64'd1);

        chk("n4_num_results", 64'(q2_cnt.size()), 64'd2);
        chk("n4_done_once", 64'(done2_cnt), 64'd1);
`ifdef RO_SCAN_SATURATE_EN
        foreach (q2_cnt[i]) chk("n4_count_sat", 64'(q2_cnt[i]), 64'd15);
`else
        foreach (q2_cnt[i]) chk("n4_count_wrap", 64'(q2_cnt[i]), 64'(50 % 16));
`endif

        // scan B: RO3 square wave of period 4
        ro_mode = 1;
        q_idx.delete(); q_cnt.delete();
        do_start(100);
        wait_done(3000, "b");
        chk("b_num_results", 64'(q_idx.size()), 64'd20);
        if (q_idx.size() == 20) begin
            chk("b_idx3_count_24_25", 64'(q_cnt[3] >= 24 && q_cnt[3] <= 25), 64'd1);
            ok = 1;
            foreach (q_cnt[i]) if (i != 3 && q_cnt[i] != 0) ok = 0;
            chk("b_others_zero", 64'(ok), 64'd1);
        end

        // scan C: backpressure at idx 5
        ro_mode = 2;
        do_start(10);
        wait_en(5, 500, "c");
        rdy_fix = 0;
        n = 0;
        while (!res_valid && n < 100) begin cyc(1); n++; end
        chk("c_valid_seen", 64'(res_valid), 64'd1);
        cap = int'(res_count);
        for (int i = 0; i < 10; i++) begin
            chk("c_hold_valid", 64'(res_valid), 64'd1);
            chk("c_hold_idx", 64'(res_idx), 64'd5);
            chk("c_hold_count", 64'(res_count), 64'(cap));
            chk("c_hold_ro_en", 64'(ro_en), 64'd0);
            cyc(1);
        end
        rdy_fix = 1;
        wait_done(1000, "c");

        // scan D: abort during GATE of idx 7, then rescan
        d0 = done_cnt;
        do_start(20);
        wait_en(7, 1000, "d");
        cyc(S + 5);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("d_abort_busy", 64'(busy), 64'd0);
        chk("d_abort_ro_en", 64'(ro_en), 64'd0);
        chk("d_abort_valid", 64'(res_valid), 64'd0);
        cyc(5);
        chk("d_no_done", 64'(done_cnt - d0), 64'd0);
        q_idx.delete(); q_cnt.delete();
        do_start(5);
        wait_done(1000, "d_rescan");
        chk("d_rescan_results", 64'(q_idx.size()), 64'd20);
        if (q_idx.size() > 0) chk("d_rescan_first_idx", 64'(q_idx[0]), 64'd0);

        // random scans: random gate, random ready, stray starts while busy
        rdy_mode = 1;
        for (int s = 0; s < 4; s++) begin
            do_start((s == 0) ? 0 : int'($urandom_range(1, 15)));
            cyc(int'($urandom_range(3, 30)));
            gate_cycles = GW'($urandom);
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            wait_done(4000, "rnd");
        end
        rdy_mode = 0; rdy_fix = 1;

        // asynchronous reset mid-GATE
        ro_mode = 0;
        do_start(100);
        cyc(S + 10);
        chk("r_pre_ro_en", 64'(ro_en), 64'd1);
        chk_on = 0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("r_async_ro_en", 64'(ro_en), 64'd0);
        chk("r_async_busy", 64'(busy), 64'd0);
        chk("r_async_valid", 64'(res_valid), 64'd0);
        chk("r_async_idx", 64'(res_idx), 64'd0);
        chk("r_async_count", 64'(res_count), 64'd0);
        chk("r_async_done", 64'(done), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
